aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Parametrised successor to the single-round AES stage wrapper in the cohort accelerator unit.
- Buffers one 22-word AES context: state plus round keys 1..10.
- Runs NUM_ROUNDS consecutive rounds, starting at FIRST_ROUND, through one shared external round core, then emits the updated context.
- Source and sink are each selectable per block: 64-bit valid/ready stream, or whole-context forward bus to/from adjacent stages.

Parameters:
- WORD_W, 64: stream word width.
- NW, 22: context words. Word 0 = state[63:0], word 1 = state[127:64], words 2r/2r+1 = round key r low/high, r = 1..10.
- IN_WORDS, 22: words consumed from the stream per block (1..NW).
- OUT_WORDS, 22: words produced to the stream per block (1..NW).
- FIRST_ROUND, 1: first round index executed (1..10).
- NUM_ROUNDS, 9: rounds executed per block. FIRST_ROUND+NUM_ROUNDS-1 must be <= 10; violation is an elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_valid  in  1  stream input valid
- in_ready  out  1  stream input ready
- in_data  in  WORD_W  stream input word
- out_valid  out  1  stream output valid
- out_ready  in  1  stream output ready
- out_data  out  WORD_W  stream output word
- fwd_in_valid  in  1  forward-bus context available
- fwd_in_ready  out  1  forward-bus context accepted
- fwd_in_data  in  NW*WORD_W  forward-bus context
- fwd_out_valid  out  1  forward-bus context valid
- fwd_out_ready  in  1  downstream accepts context
- fwd_out_data  out  NW*WORD_W  buffered context, word i at bits [i*WORD_W +: WORD_W]
- src_stream  in  1  1 = load from stream, 0 = load from forward bus
- dst_stream  in  1  1 = emit to stream, 0 = emit to forward bus
- rc_start  out  1  one-cycle round-core launch
- rc_state  out  128  round input state {word1,word0}
- rc_key  out  128  round key {word 2r+1, word 2r}
- rc_last  out  1  current round is round 10 (no MixColumns)
- rc_done  in  1  round-core result valid (single-cycle pulse)
- rc_result  in  128  round-core output state
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, ISSUE, WAIT, EMIT.
- Reset, and any cycle with rst high: state = IDLE, counters = 0, context buffer = 0. All outputs are 0: in_ready, out_valid, out_data, fwd_in_ready, fwd_out_valid, rc_start, rc_last, busy.
- rst mid-block abandons the block. Any later rc_done is ignored.
- IDLE:
  - src_stream and dst_stream are captured into mode registers on exit and held for the whole block. Mid-block changes have no effect.
  - Go to LOAD if src_stream=1 and in_valid=1.
  - Go to LOAD if src_stream=0 and fwd_in_valid=1.
- LOAD, stream mode:
  - in_ready=1. Each handshake writes word[cnt] and increments cnt.
  - On the first word, words IN_WORDS..NW-1 are cleared to 0.
  - After the handshake at cnt = IN_WORDS-1: cnt=0, round=FIRST_ROUND, go to ISSUE.
- LOAD, forward mode:
  - fwd_in_ready=1 for exactly one cycle. The whole context is captured that cycle; go to ISSUE.
- ISSUE:
  - rc_start=1 for one cycle. rc_state = {word1,word0}, rc_key = key[round], rc_last = (round==10).
  - Go to WAIT.
- WAIT:
  - rc_key and rc_last are held stable.
  - On rc_done: word0 = rc_result[63:0], word1 = rc_result[127:64], done_cnt+1, round+1.
  - If done_cnt+1 == NUM_ROUNDS, go to EMIT; otherwise go to ISSUE.
  - Round-core latency is unbounded; there is no timeout.
  - An rc_done pulse outside WAIT is ignored.
- Per-round cost = 1 + core latency cycles.
- EMIT, stream mode:
  - out_valid=1, out_data = word[cnt]. On handshake, cnt+1.
  - After the handshake at cnt = OUT_WORDS-1, go to IDLE.
  - out_data = 0 whenever out_valid=0. Data is held stable while stalled.
- EMIT, forward mode:
  - fwd_out_valid=1, held until fwd_out_ready=1, then go to IDLE.
- Key words pass through unmodified.
- in_ready=0 outside LOAD, so back-to-back blocks insert one IDLE cycle.
- Counters are $clog2(NW)+1 bits wide. The round index is 4 bits.

Test Plan:
Bench stub core: result = state ^ key after 3 cycles.
1. Stream in/out, FIRST_ROUND=1, NUM_ROUNDS=9. Word0=0x0, word1=0x0, word 2r = r, word 2r+1 = r<<32.
   -> 9 rc_start pulses with rc_key low = 1..9.
   -> Out word0 = 1^2^…^9 = 0x1, word1 = 0x1<<32; words 2..21 echo the input.
   -> rc_last never asserted.
2. FIRST_ROUND=10, NUM_ROUNDS=1, forward in/out.
   -> Exactly one rc_start with rc_last=1 and rc_key = {word21,word20}.
   -> fwd_out_valid held across 5 cycles of fwd_out_ready=0; context unchanged until the ready cycle.
3. IN_WORDS=4, OUT_WORDS=2, stream.
   -> Words 4..21 read as 0, so round keys 2..9 are zero.
   -> Exactly 2 output handshakes.
4. out_ready toggling 1,0,0,1 during EMIT.
   -> out_data stable during stalls; no word skipped or duplicated.
5. Assert rst for 1 cycle in WAIT after round 3, with a stray rc_done 2 cycles later.
   -> All outputs 0, state IDLE, stray done ignored.
   -> Next block produces correct results.
6. Flip src_stream/dst_stream mid-block.
   -> No effect; the captured mode is used until IDLE.

Source files
------------

// File: rtl/aes_round_sequencer_if.sv
// Signal bundle around one aes_round_sequencer: stream in/out, whole-context forward bus,
// per-block source/sink selection and the shared round-core launch/result pair.
interface aes_round_sequencer_if #(
    parameter int WORD_W = 64,
    parameter int NW     = 22
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_W-1:0]      in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_W-1:0]      out_data;
    logic                   fwd_in_valid;
    logic                   fwd_in_ready;
    logic [NW*WORD_W-1:0]   fwd_in_data;
    logic                   fwd_out_valid;
    logic                   fwd_out_ready;
    logic [NW*WORD_W-1:0]   fwd_out_data;
    logic                   src_stream;
    logic                   dst_stream;
    logic                   rc_start;
    logic [127:0]           rc_state;
    logic [127:0]           rc_key;
    logic                   rc_last;
    logic                   rc_done;
    logic [127:0]           rc_result;
    logic                   busy;

    modport master (
        output in_valid, in_data, out_ready, fwd_in_valid, fwd_in_data, fwd_out_ready,
               src_stream, dst_stream, rc_done, rc_result,
        input  in_ready, out_valid, out_data, fwd_in_ready, fwd_out_valid, fwd_out_data,
               rc_start, rc_state, rc_key, rc_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, fwd_in_valid, fwd_in_data, fwd_out_ready,
               src_stream, dst_stream, rc_done, rc_result,
        output in_ready, out_valid, out_data, fwd_in_ready, fwd_out_valid, fwd_out_data,
               rc_start, rc_state, rc_key, rc_last, busy
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Buffers one AES context (state + round keys 1..10), runs NUM_ROUNDS rounds from FIRST_ROUND
// through an external round core, then emits the context to the stream or the forward bus.
module aes_round_sequencer #(
    parameter int WORD_W      = 64,
    parameter int NW          = 22,
    parameter int IN_WORDS    = 22,
    parameter int OUT_WORDS   = 22,
    parameter int FIRST_ROUND = 1,
    parameter int NUM_ROUNDS  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_round_sequencer_if.slave bus
);
    localparam int CW = $clog2(NW) + 1;

    if (FIRST_ROUND < 1 || NUM_ROUNDS < 1 || FIRST_ROUND + NUM_ROUNDS - 1 > 10 ||
        IN_WORDS < 1 || IN_WORDS > NW || OUT_WORDS < 1 || OUT_WORDS > NW ||
        NW != 22 || WORD_W != 64) begin : g_bad_cfg
        $error("aes_round_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, EMIT} state_t;

    state_t            state_q, state_d;
    logic              src_mode_q, src_mode_d;
    logic              dst_mode_q, dst_mode_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     done_cnt_q, done_cnt_d;
    logic [3:0]        round_q, round_d;
    logic [WORD_W-1:0] ctx_q [NW];
    logic [WORD_W-1:0] ctx_d [NW];

    logic              in_ready_c;
    logic              out_valid_c;
    logic [WORD_W-1:0] out_data_c;
    logic              fwd_in_ready_c;
    logic              fwd_out_valid_c;
    logic              rc_start_c;
    logic              core_active;
    logic [WORD_W-1:0] cur_word;
    logic [127:0]      round_key;
    logic [NW*WORD_W-1:0] ctx_flat;

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NW; i++) begin
            if (cnt_q == CW'(i)) cur_word = ctx_q[i];
        end
    end

    // Round r's key lives in words 2r/2r+1; a compare-mux keeps the index in range for any round_q.
    always_comb begin
        round_key = '0;
        for (int r = 1; r <= 10; r++) begin
            if (round_q == 4'(r)) round_key = {ctx_q[2*r+1], ctx_q[2*r]};
        end
    end

    always_comb begin
        ctx_flat = '0;
        for (int i = 0; i < NW; i++) ctx_flat[i*WORD_W +: WORD_W] = ctx_q[i];
    end

    always_comb begin
        state_d         = state_q;
        src_mode_d      = src_mode_q;
        dst_mode_d      = dst_mode_q;
        cnt_d           = cnt_q;
        done_cnt_d      = done_cnt_q;
        round_d         = round_q;
        ctx_d           = ctx_q;
        in_ready_c      = 1'b0;
        out_valid_c     = 1'b0;
        out_data_c      = '0;
        fwd_in_ready_c  = 1'b0;
        fwd_out_valid_c = 1'b0;
        rc_start_c      = 1'b0;

        case (state_q)
            IDLE: begin
                // Re-captured every idle cycle, so the value held is the one seen on exit.
                src_mode_d = bus.src_stream;
                dst_mode_d = bus.dst_stream;
                cnt_d      = '0;
                done_cnt_d = '0;
                if (bus.src_stream ? bus.in_valid : bus.fwd_in_valid) state_d = LOAD;
            end

            LOAD: begin
                if (src_mode_q) begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        if (cnt_q == '0) begin
                            for (int i = IN_WORDS; i < NW; i++) ctx_d[i] = '0;
                        end
                        for (int i = 0; i < NW; i++) begin
                            if (cnt_q == CW'(i)) ctx_d[i] = bus.in_data;
                        end
                        if (cnt_q == CW'(IN_WORDS - 1)) begin
                            cnt_d   = '0;
                            round_d = 4'(FIRST_ROUND);
                            state_d = ISSUE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    fwd_in_ready_c = 1'b1;
                    for (int i = 0; i < NW; i++) ctx_d[i] = bus.fwd_in_data[i*WORD_W +: WORD_W];
                    round_d = 4'(FIRST_ROUND);
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                rc_start_c = 1'b1;
                state_d    = WAIT;
            end

            WAIT: begin
                if (bus.rc_done) begin
                    ctx_d[0]   = bus.rc_result[63:0];
                    ctx_d[1]   = bus.rc_result[127:64];
                    done_cnt_d = done_cnt_q + 1'b1;
                    round_d    = round_q + 1'b1;
                    if (done_cnt_q + 1'b1 == CW'(NUM_ROUNDS)) begin
                        cnt_d   = '0;
                        state_d = EMIT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            EMIT: begin
                if (dst_mode_q) begin
                    out_valid_c = 1'b1;
                    out_data_c  = cur_word;
                    if (bus.out_ready) begin
                        if (cnt_q == CW'(OUT_WORDS - 1)) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    fwd_out_valid_c = 1'b1;
                    if (bus.fwd_out_ready) state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_mode_q <= 1'b0;
            dst_mode_q <= 1'b0;
            cnt_q      <= '0;
            done_cnt_q <= '0;
            round_q    <= '0;
            for (int i = 0; i < NW; i++) ctx_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            src_mode_q <= src_mode_d;
            dst_mode_q <= dst_mode_d;
            cnt_q      <= cnt_d;
            done_cnt_q <= done_cnt_d;
            round_q    <= round_d;
            ctx_q      <= ctx_d;
        end
    end

    // Outputs are forced low combinationally so the reset cycle itself already shows an idle block.
    assign core_active       = !rst && (state_q == ISSUE || state_q == WAIT);
    assign bus.in_ready      = in_ready_c & ~rst;
    assign bus.out_valid     = out_valid_c & ~rst;
    assign bus.out_data      = rst ? '0 : out_data_c;
    assign bus.fwd_in_ready  = fwd_in_ready_c & ~rst;
    assign bus.fwd_out_valid = fwd_out_valid_c & ~rst;
    assign bus.fwd_out_data  = ctx_flat;
    assign bus.rc_start      = rc_start_c & ~rst;
    assign bus.rc_state      = core_active ? {ctx_q[1], ctx_q[0]} : '0;
    assign bus.rc_key        = core_active ? round_key : '0;
    assign bus.rc_last       = core_active && (round_q == 4'd10);
    assign bus.busy          = !rst && (state_q != IDLE);
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: three configurations share one clock, each with a
// stub round core (result = state ^ key three cycles after launch) and queue-driven monitors.
module tb_aes_round_sequencer;
    localparam int NW   = 22;
    localparam int CTXW = NW * 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA, rstBC;
    int   nCompared = 0;
    int   nMismatch = 0;

    aes_round_sequencer_if #(.WORD_W(64), .NW(NW)) busA ();
    aes_round_sequencer_if #(.WORD_W(64), .NW(NW)) busB ();
    aes_round_sequencer_if #(.WORD_W(64), .NW(NW)) busC ();

    aes_round_sequencer #(.FIRST_ROUND(1), .NUM_ROUNDS(9)) dutA (.clk(clk), .rst(rstA), .bus(busA));
    aes_round_sequencer #(.FIRST_ROUND(10), .NUM_ROUNDS(1)) dutB (.clk(clk), .rst(rstBC), .bus(busB));
    aes_round_sequencer #(.IN_WORDS(4), .OUT_WORDS(2)) dutC (.clk(clk), .rst(rstBC), .bus(busC));

    logic [1:0]   dlyA = 2'd0, dlyB = 2'd0, dlyC = 2'd0;
    logic [127:0] resA, resB, resC;

    always @(posedge clk) begin
        busA.rc_done <= 1'b0;
        if (busA.rc_start) begin resA <= busA.rc_state ^ busA.rc_key; dlyA <= 2'd3; end
        else if (dlyA != 2'd0) begin
            dlyA <= dlyA - 2'd1;
            if (dlyA == 2'd1) begin busA.rc_done <= 1'b1; busA.rc_result <= resA; end
        end
    end

    always @(posedge clk) begin
        busB.rc_done <= 1'b0;
        if (busB.rc_start) begin resB <= busB.rc_state ^ busB.rc_key; dlyB <= 2'd3; end
        else if (dlyB != 2'd0) begin
            dlyB <= dlyB - 2'd1;
            if (dlyB == 2'd1) begin busB.rc_done <= 1'b1; busB.rc_result <= resB; end
        end
    end

    always @(posedge clk) begin
        busC.rc_done <= 1'b0;
        if (busC.rc_start) begin resC <= busC.rc_state ^ busC.rc_key; dlyC <= 2'd3; end
        else if (dlyC != 2'd0) begin
            dlyC <= dlyC - 2'd1;
            if (dlyC == 2'd1) begin busC.rc_done <= 1'b1; busC.rc_result <= resC; end
        end
    end

    logic [63:0]     inQA[$], inQC[$];
    logic [63:0]     expOutA[$], expOutC[$];
    logic [128:0]    expRcA[$], expRcB[$], expRcC[$];
    logic [CTXW-1:0] expFwdB[$];
    int              hsC = 0;
    bit              tookA, tookC, heldA, heldC, stallMode;
    logic [63:0]     heldDataA, heldDataC;
    logic [3:0]      stallPat = 4'b1001;

    task automatic checkOutput(string name, logic [255:0] act, logic [255:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic flagUnexpected(string name, logic [255:0] act);
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL %s: got %0h, required nothing (no expectation queued)", name, act);
    endtask

    task automatic checkCtx(string name, logic [CTXW-1:0] act, logic [CTXW-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            for (int i = 0; i < NW; i++) begin
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
                    $display("[TB] FAIL %s: word %0d got %0h, required %0h", name, i,
                             act[i*64 +: 64], exp[i*64 +: 64]);
                    break;
                end
            end
        end
    endtask

    // Stream input drivers: the head of each queue is offered until a handshake is seen.
    initial begin
        busA.in_valid = 1'b0; busA.in_data = '0;
        forever begin
            @(negedge clk); tookA = busA.in_valid && busA.in_ready;
            @(posedge clk); #1;
            if (tookA) void'(inQA.pop_front());
            busA.in_valid = (inQA.size() != 0);
            busA.in_data  = (inQA.size() != 0) ? inQA[0] : 64'd0;
        end
    end

    initial begin
        busC.in_valid = 1'b0; busC.in_data = '0;
        forever begin
            @(negedge clk); tookC = busC.in_valid && busC.in_ready;
            @(posedge clk); #1;
            if (tookC) void'(inQC.pop_front());
            busC.in_valid = (inQC.size() != 0);
            busC.in_data  = (inQC.size() != 0) ? inQC[0] : 64'd0;
        end
    end

    initial begin
        int phase = 0;
        busA.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stallMode) begin
                busA.out_ready = stallPat[phase];
                phase = (phase + 1) % 4;
            end else begin
                busA.out_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (heldA && busA.out_valid) checkOutput("A out_data held in stall", busA.out_data, heldDataA);
        heldA = 1'b0;
        if (busA.out_valid && busA.out_ready) begin
            if (expOutA.size() == 0) flagUnexpected("A out word", busA.out_data);
            else checkOutput("A out word", busA.out_data, expOutA.pop_front());
        end else if (busA.out_valid) begin
            heldA = 1'b1; heldDataA = busA.out_data;
        end
        if (busA.rc_start) begin
            if (expRcA.size() == 0) flagUnexpected("A rc_start {last,key}", {busA.rc_last, busA.rc_key});
            else checkOutput("A rc_start {last,key}", {busA.rc_last, busA.rc_key}, expRcA.pop_front());
        end
        if (busA.fwd_out_valid) flagUnexpected("A fwd_out_valid", busA.fwd_out_valid);
    end

    always @(negedge clk) begin
        if (busB.rc_start) begin
            if (expRcB.size() == 0) flagUnexpected("B rc_start {last,key}", {busB.rc_last, busB.rc_key});
            else checkOutput("B rc_start {last,key}", {busB.rc_last, busB.rc_key}, expRcB.pop_front());
        end
        if (busB.fwd_out_valid && busB.fwd_out_ready) begin
            if (expFwdB.size() == 0) flagUnexpected("B fwd_out context", busB.fwd_out_data[255:0]);
            else checkCtx("B fwd_out context", busB.fwd_out_data, expFwdB.pop_front());
        end
        if (busB.out_valid) flagUnexpected("B out_valid", busB.out_valid);
    end

    always @(negedge clk) begin
        if (heldC && busC.out_valid) checkOutput("C out_data held in stall", busC.out_data, heldDataC);
        heldC = 1'b0;
        if (busC.out_valid && busC.out_ready) begin
            hsC++;
            if (expOutC.size() == 0) flagUnexpected("C out word", busC.out_data);
            else checkOutput("C out word", busC.out_data, expOutC.pop_front());
        end else if (busC.out_valid) begin
            heldC = 1'b1; heldDataC = busC.out_data;
        end
        if (busC.rc_start) begin
            if (expRcC.size() == 0) flagUnexpected("C rc_start {last,key}", {busC.rc_last, busC.rc_key});
            else checkOutput("C rc_start {last,key}", {busC.rc_last, busC.rc_key}, expRcC.pop_front());
        end
        if (busC.fwd_out_valid) flagUnexpected("C fwd_out_valid", busC.fwd_out_valid);
    end

    function automatic logic [63:0] patWord(int i);
        if (i < 2) return 64'd0;
        if (i % 2 == 0) return 64'(i / 2);
        return 64'(i / 2) << 32;
    endfunction

    function automatic logic [63:0] bWord(int i);
        return {32'hB0B0_0000 | 32'(i), 32'h0000_1000 + 32'(i)};
    endfunction

    function automatic logic [7:0] flagsOf(int inst);
        case (inst)
            0: return {1'b0, busA.busy, busA.in_ready, busA.out_valid, busA.fwd_in_ready,
                       busA.fwd_out_valid, busA.rc_start, busA.rc_last};
            1: return {1'b0, busB.busy, busB.in_ready, busB.out_valid, busB.fwd_in_ready,
                       busB.fwd_out_valid, busB.rc_start, busB.rc_last};
            default: return {1'b0, busC.busy, busC.in_ready, busC.out_valid, busC.fwd_in_ready,
                             busC.fwd_out_valid, busC.rc_start, busC.rc_last};
        endcase
    endfunction

    function automatic logic [63:0] outDataOf(int inst);
        case (inst)
            0: return busA.out_data;
            1: return busB.out_data;
            default: return busC.out_data;
        endcase
    endfunction

    function automatic bit instDone(int inst);
        case (inst)
            0: return !busA.busy && inQA.size() == 0 && expOutA.size() == 0 && expRcA.size() == 0;
            1: return !busB.busy && expRcB.size() == 0 && expFwdB.size() == 0;
            default: return !busC.busy && inQC.size() == 0 && expOutC.size() == 0 && expRcC.size() == 0;
        endcase
    endfunction

    task automatic checkIdle(string name, int inst);
        checkOutput({name, " control flags"}, flagsOf(inst), 0);
        checkOutput({name, " out_data"}, outDataOf(inst), 0);
    endtask

    task automatic reportTimeout(string name, int budget);
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL %s: event not seen within %0d cycles, required it", name, budget);
    endtask

    task automatic waitDone(string name, int inst, int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (!instDone(inst) && n < budget);
        checkOutput({name, " drained and idle"}, instDone(inst), 1);
        if (!instDone(inst)) begin
            inQA.delete(); expOutA.delete(); expRcA.delete();
            expRcB.delete(); expFwdB.delete();
            inQC.delete(); expOutC.delete(); expRcC.delete();
        end
    endtask

    // Default A block: round keys r / r<<32, zero state; XOR of keys 1..9 is 1 in each half.
    task automatic applyStimulus();
        for (int r = 1; r <= 9; r++) expRcA.push_back({1'b0, 64'(r) << 32, 64'(r)});
        expOutA.push_back(64'h0000_0000_0000_0001);
        expOutA.push_back(64'h0000_0001_0000_0000);
        for (int i = 2; i < NW; i++) expOutA.push_back(patWord(i));
        for (int i = 0; i < NW; i++) inQA.push_back(patWord(i));
    endtask

    initial begin
        int n;
        int k;
        logic [CTXW-1:0] ctx;
        logic [CTXW-1:0] expCtx;

        rstA = 1'b1; rstBC = 1'b1; stallMode = 1'b0;
        busA.src_stream = 1'b1; busA.dst_stream = 1'b1;
        busA.fwd_in_valid = 1'b0; busA.fwd_in_data = '0; busA.fwd_out_ready = 1'b0;
        busB.src_stream = 1'b0; busB.dst_stream = 1'b0;
        busB.in_valid = 1'b0; busB.in_data = '0; busB.out_ready = 1'b0;
        busB.fwd_in_valid = 1'b0; busB.fwd_in_data = '0; busB.fwd_out_ready = 1'b0;
        busC.src_stream = 1'b1; busC.dst_stream = 1'b1; busC.out_ready = 1'b1;
        busC.fwd_in_valid = 1'b0; busC.fwd_in_data = '0; busC.fwd_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1; rstA = 1'b0; rstBC = 1'b0;
        @(negedge clk);
        checkIdle("reset A", 0);
        checkIdle("reset B", 1);
        checkIdle("reset C", 2);

        $display("[TB] test 1: stream in/out, rounds 1..9");
        applyStimulus();
        waitDone("T1 stream block", 0, 400);
        checkIdle("T1 after block A", 0);

        $display("[TB] test 2: round 10 only, forward in/out with stalled sink");
        for (int i = 0; i < NW; i++) ctx[i*64 +: 64] = bWord(i);
        expCtx = ctx;
        expCtx[63:0]   = bWord(0) ^ bWord(20);
        expCtx[127:64] = bWord(1) ^ bWord(21);
        expRcB.push_back({1'b1, bWord(21), bWord(20)});
        expFwdB.push_back(expCtx);
        @(posedge clk); #1;
        busB.fwd_in_data = ctx; busB.fwd_in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!busB.fwd_in_ready && n < 20);
        if (!busB.fwd_in_ready) reportTimeout("T2 fwd_in_ready", 20);
        @(posedge clk); #1; busB.fwd_in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!busB.fwd_out_valid && n < 50);
        if (!busB.fwd_out_valid) reportTimeout("T2 fwd_out_valid", 50);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checkOutput("T2 fwd_out_valid held in stall", busB.fwd_out_valid, 1);
            checkCtx("T2 context stable in stall", busB.fwd_out_data, expCtx);
        end
        @(posedge clk); #1; busB.fwd_out_ready = 1'b1;
        waitDone("T2 forward block", 1, 50);
        @(posedge clk); #1; busB.fwd_out_ready = 1'b0;

        $display("[TB] test 3: 4 words in, 2 words out");
        expRcC.push_back({1'b0, 64'h20, 64'h10});
        for (int r = 2; r <= 9; r++) expRcC.push_back('0);
        expOutC.push_back(64'h1A);
        expOutC.push_back(64'h2B);
        inQC.push_back(64'hA); inQC.push_back(64'hB); inQC.push_back(64'h10); inQC.push_back(64'h20);
        waitDone("T3 short block", 2, 300);
        repeat (3) @(negedge clk);
        checkOutput("T3 output handshake count", hsC, 2);

        $display("[TB] test 4: out_ready 1,0,0,1 during emit");
        stallMode = 1'b1;
        applyStimulus();
        waitDone("T4 stalled emit", 0, 500);
        stallMode = 1'b0;

        $display("[TB] test 5: reset in WAIT of round 4 with stray rc_done");
        applyStimulus();
        k = 0; n = 0;
        do begin @(negedge clk); n++; if (busA.rc_start) k++; end while (k < 4 && n < 200);
        if (k < 4) reportTimeout("T5 fourth rc_start", 200);
        @(posedge clk); #1;
        rstA = 1'b1;
        inQA.delete(); expOutA.delete(); expRcA.delete();
        @(negedge clk);
        checkIdle("T5 during rst", 0);
        @(posedge clk); #1; rstA = 1'b0;
        @(negedge clk);
        checkIdle("T5 after rst", 0);
        repeat (6) @(negedge clk);
        checkIdle("T5 after stray rc_done", 0);
        checkOutput("T5 round-4 key zeroed", busA.rc_key, 0);
        applyStimulus();
        waitDone("T5 recovery block", 0, 400);

        $display("[TB] test 6: mode inputs flipped mid-block");
        applyStimulus();
        n = 0;
        do begin @(negedge clk); n++; end while (inQA.size() > 11 && n < 100);
        @(posedge clk); #1;
        busA.src_stream = 1'b0; busA.dst_stream = 1'b0;
        busA.fwd_in_data = '1; busA.fwd_in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!busA.rc_start && n < 100);
        if (!busA.rc_start) reportTimeout("T6 first rc_start", 100);
        @(posedge clk); #1; busA.fwd_in_valid = 1'b0;
        waitDone("T6 flipped-mode block", 0, 400);
        @(posedge clk); #1; busA.src_stream = 1'b1; busA.dst_stream = 1'b1;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
